// File: rtl/ps2_packet_framer_if.sv
// Byte-stream-in / packet-out bundle between a PS/2 byte source and the packet framer.
// The master drives the byte stream; the slave (framer) returns done, pkt_data and err.
interface ps2_packet_framer_if #(
    parameter int PKT_BYTES = 3,
    parameter int BYTE_W    = 8
);
    logic [BYTE_W-1:0]           in;
    logic                        in_valid;
    logic                        done;
    logic [PKT_BYTES*BYTE_W-1:0] pkt_data;
    logic                        err;

    modport master (
        output in,
        output in_valid,
        input  done,
        input  pkt_data,
        input  err
    );

    modport slave (
        input  in,
        input  in_valid,
        output done,
        output pkt_data,
        output err
    );
endinterface

// File: rtl/ps2_packet_framer.sv
// Hunts for a byte with the sync bit set, gathers PKT_BYTES bytes, then publishes them as one word with a done pulse.
// Latency: done and pkt_data one cycle after the final byte. There is no backpressure; bytes are taken whenever in_valid is high.
// Optional idle abort inside a packet is enabled by defining PS2_FRAMER_TIMEOUT_EN.
module ps2_packet_framer #(
    parameter int PKT_BYTES   = 3,
    parameter int BYTE_W      = 8,
    parameter int SYNC_BIT    = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                resetn,
    ps2_packet_framer_if.slave  bus
);
    localparam int CNT_W = $clog2(PKT_BYTES);
    localparam int PKT_W = PKT_BYTES * BYTE_W;

    typedef enum logic {
        SEEK    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PKT_W-1:0]   asm_q, asm_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic               done_q, done_d;
    logic               take;
    logic               last;
    logic               tmo_hit;
    int                 lane;

    // In COLLECT every valid byte is taken; in SEEK only a sync-marked one.
    assign take = bus.in_valid && ((state_q == COLLECT) || bus.in[SYNC_BIT]);
    assign last = bus.in_valid && (state_q == COLLECT) &&
                  (cnt_q == CNT_W'(PKT_BYTES - 1));

`ifdef PS2_FRAMER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q;

    // A byte arriving on the limit cycle wins because tmo_hit requires !in_valid.
    assign tmo_hit = (state_q == COLLECT) && !bus.in_valid &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_d = '0;
        if ((state_q == COLLECT) && !bus.in_valid && !tmo_hit)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn)
            state_q <= SEEK;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEEK:    if (take) state_d = COLLECT;
            COLLECT: if (last || tmo_hit) state_d = SEEK;
            default: state_d = SEEK;
        endcase
    end

    // Byte cnt lands in lane PKT_BYTES-1-cnt so byte 0 ends up in the MSBs.
    always_comb begin
        cnt_d  = cnt_q;
        asm_d  = asm_q;
        pkt_d  = pkt_q;
        done_d = 1'b0;
        lane   = PKT_BYTES - 1 - int'(cnt_q);
        if (take) begin
            asm_d[lane*BYTE_W +: BYTE_W] = bus.in;
            cnt_d = cnt_q + 1'b1;
        end
        if (last) begin
            pkt_d  = asm_d;
            cnt_d  = '0;
            done_d = 1'b1;
        end
        if (tmo_hit)
            cnt_d = '0;
    end

    always_comb begin
        bus.done     = done_q;
        bus.pkt_data = pkt_q;
`ifdef PS2_FRAMER_TIMEOUT_EN
        bus.err      = err_q;
`else
        bus.err      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            asm_q  <= '0;
            pkt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            asm_q  <= asm_d;
            pkt_q  <= pkt_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_ps2_packet_framer.sv
// Directed vectors against a queue-based packet model, plus literal packet expectations per scenario.
module tb_ps2_packet_framer;
    localparam int PB = 3;
    localparam int BW = 8;
    localparam int SB = 3;
    localparam int TC = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ps2_packet_framer_if #(.PKT_BYTES(PB), .BYTE_W(BW)) bus ();

    ps2_packet_framer #(
        .PKT_BYTES(PB), .BYTE_W(BW), .SYNC_BIT(SB), .TIMEOUT_CYC(TC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit armed   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: bytes of the packet being gathered, what the outputs must show next cycle.
    logic [BW-1:0]    m_q[$];
    logic             m_done = 1'b0;
    logic             m_err  = 1'b0;
    logic [PB*BW-1:0] m_pkt  = '0;
    int               m_idle = 0;
    bit               tmo_en;

    initial begin
        tmo_en = 1'b0;
`ifdef PS2_FRAMER_TIMEOUT_EN
        tmo_en = 1'b1;
`endif
    end

    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!resetn) begin
            m_q.delete();
            m_pkt  = '0;
            m_idle = 0;
        end else if (bus.in_valid) begin
            if (m_q.size() > 0 || bus.in[SB]) m_q.push_back(bus.in);
            m_idle = 0;
            if (m_q.size() == PB) begin
                for (int i = 0; i < PB; i++) m_pkt[(PB-1-i)*BW +: BW] = m_q[i];
                m_done = 1'b1;
                m_q.delete();
            end
        end else if (m_q.size() > 0 && tmo_en) begin
            m_idle++;
            if (m_idle == TC) begin
                m_q.delete();
                m_idle = 0;
                m_err  = 1'b1;
            end
        end
    end

    // Captured outputs for the literal per-scenario checks.
    logic [PB*BW-1:0] got_pkt[$];
    int               got_cyc[$];
    int               got_err = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("done", bus.done, m_done);
            chk("pkt_data", bus.pkt_data, m_pkt);
            chk("err", bus.err, m_err);
            if (bus.done) begin
                got_pkt.push_back(bus.pkt_data);
                got_cyc.push_back(cyc);
            end
            if (bus.err) got_err++;
        end
    end

    task automatic drive(input logic v, input logic [BW-1:0] b);
        bus.in       = b;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    task automatic send(input logic [BW-1:0] bytes[$]);
        foreach (bytes[i]) drive(1'b1, bytes[i]);
    endtask

    task automatic clear_cap();
        got_pkt.delete();
        got_cyc.delete();
        got_err = 0;
    endtask

    function automatic logic [63:0] pk(input int i);
        return (i < got_pkt.size()) ? 64'(got_pkt[i]) : 64'hDEAD_BEEF;
    endfunction

    function automatic int pc(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1;
    endfunction

    int last_edge;

    initial begin
        bus.in       = '0;
        bus.in_valid = 1'b0;
        resetn       = 1'b0;
        @(posedge clk);
        armed = 1'b1;
        @(negedge clk);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_pkt", bus.pkt_data, 24'h000000);
        chk("rst_err", bus.err, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);

        // Basic packet; done in the cycle after the final byte edge.
        clear_cap();
        send('{8'h08, 8'h11, 8'h22});
        last_edge = cyc;
        idle(3);
        chk("p030_count", got_pkt.size(), 1);
        chk("p030_pkt", pk(0), 24'h081122);
        chk("p030_lat", pc(0), last_edge);
        chk("p030_err", got_err, 0);

        // Non-sync bytes in SEEK are dropped.
        clear_cap();
        send('{8'h00, 8'h07, 8'hF0, 8'h0C, 8'hAA, 8'h55});
        idle(3);
        chk("p031_count", got_pkt.size(), 1);
        chk("p031_pkt", pk(0), 24'h0CAA55);

        // Back-to-back packets with no gap.
        clear_cap();
        send('{8'h08, 8'h01, 8'h02, 8'h18, 8'h03, 8'h04});
        idle(3);
        chk("p032_count", got_pkt.size(), 2);
        chk("p032_pkt0", pk(0), 24'h080102);
        chk("p032_pkt1", pk(1), 24'h180304);
        chk("p032_gap", pc(1) - pc(0), 3);

`ifdef PS2_FRAMER_TIMEOUT_EN
        // Gap one short of the limit, then a byte on the limit cycle: accepted.
        clear_cap();
        send('{8'h08, 8'h09});
        idle(TC - 1);
        send('{8'h0A});
        idle(3);
        chk("p033_count", got_pkt.size(), 1);
        chk("p033_pkt", pk(0), 24'h08090A);
        chk("p033_err", got_err, 0);
`else
        clear_cap();
        send('{8'h08, 8'h09});
        idle(5);
        send('{8'h0A});
        idle(3);
        chk("p033_count", got_pkt.size(), 1);
        chk("p033_pkt", pk(0), 24'h08090A);
`endif

        // Reset mid-packet discards the partial packet.
        clear_cap();
        send('{8'h08, 8'h11});
        resetn = 1'b0;
        drive(1'b0, '0);
        resetn = 1'b1;
        send('{8'h33, 8'h44, 8'h28, 8'h01});
        chk("p034_early", got_pkt.size(), 0);
        send('{8'h02});
        idle(3);
        chk("p034_count", got_pkt.size(), 1);
        chk("p034_pkt", pk(0), 24'h280102);
        chk("p034_err", got_err, 0);

`ifdef PS2_FRAMER_TIMEOUT_EN
        clear_cap();
        send('{8'h08});
        idle(TC);
        idle(2);
        chk("p035_err", got_err, 1);
        chk("p035_hold", bus.pkt_data, 24'h280102);
        chk("p035_nodone", got_pkt.size(), 0);
        send('{8'h0F, 8'h01, 8'h02});
        idle(3);
        chk("p035_count", got_pkt.size(), 1);
        chk("p035_pkt", pk(0), 24'h0F0102);
`else
        // Without the timeout a partial packet waits indefinitely.
        clear_cap();
        send('{8'h08});
        idle(20);
        chk("wait_err", got_err, 0);
        chk("wait_nodone", got_pkt.size(), 0);
        send('{8'h0F, 8'h01});
        idle(3);
        chk("wait_count", got_pkt.size(), 1);
        chk("wait_pkt", pk(0), 24'h080F01);
`endif

        armed = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
